// File: rtl/riscv_hazard_pkg.sv
// Shared types and helpers for the hazard/forwarding scoreboard.
// The in-flight tag format and the forwarding-select encoding live here.
package riscv_hazard_pkg;

  // Tags store rd zero-extended to this width, so REG_W may be at most MAX_REG_W.
  localparam int MAX_REG_W = 8;
  localparam int FWD_RF    = 0;

  typedef struct packed {
    logic                 valid;
    logic [MAX_REG_W-1:0] rd;
    logic                 we;
    logic                 is_load;
  } entry_t;

  // The select must encode "register file" plus one code per tracked entry.
  function automatic int sel_width(input int depth);
    return (depth < 1) ? 1 : $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/riscv_hazard_scoreboard_match.sv
// Per-operand dependency search over the in-flight tags.
// Reports the youngest matching writer and whether its data is not yet available.
module hazard_match
  import riscv_hazard_pkg::*;
#(
  parameter int DEPTH      = 3,
  parameter int REG_W      = 5,
  parameter int LOAD_READY = 1,
  parameter int SEL_W      = sel_width(DEPTH)
) (
  input  logic [REG_W-1:0]   rs,
  input  logic               used,
  input  entry_t [DEPTH-1:0] entries,
  output logic               hit,
  output logic [SEL_W-1:0]   index,
  output logic               load_use
);

  logic hit_load;
  int   hit_idx;

  // NOTE: every output gets a default before any condition, otherwise the
  // untaken paths would infer latches.
  always_comb begin
    hit      = 1'b0;
    index    = '0;
    hit_load = 1'b0;
    hit_idx  = 0;
    if (used && (rs != '0)) begin
      // Scan oldest to youngest so the youngest match is the one left standing.
      for (int i = DEPTH - 1; i >= 0; i--) begin
        if (entries[i].valid && entries[i].we &&
            (entries[i].rd == MAX_REG_W'(rs))) begin
          hit      = 1'b1;
          index    = SEL_W'(i);
          hit_load = entries[i].is_load;
          hit_idx  = i;
        end
      end
    end
    load_use = hit && hit_load && (hit_idx < LOAD_READY);
  end

endmodule

// File: rtl/riscv_hazard_scoreboard.sv
// Interlock and bypass controller: tag shift chain, stall/flush, operand
// forwarding muxes and saturating stall/flush statistics.
module riscv_hazard_scoreboard
  import riscv_hazard_pkg::*;
#(
  parameter int DEPTH      = 3,
  parameter int DATA_W     = 32,
  parameter int REG_W      = 5,
  parameter int LOAD_READY = 1,
  parameter int CNT_W      = 16,
  localparam int SEL_W     = sel_width(DEPTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    dec_valid,
  input  logic [REG_W-1:0]        dec_rs1,
  input  logic [REG_W-1:0]        dec_rs2,
  input  logic                    dec_rs1_used,
  input  logic                    dec_rs2_used,
  input  logic [REG_W-1:0]        dec_rd,
  input  logic                    dec_rd_we,
  input  logic                    dec_is_load,
  input  logic                    branch_taken,
  input  logic [DATA_W-1:0]       rf_rs1_data,
  input  logic [DATA_W-1:0]       rf_rs2_data,
  input  logic [DEPTH*DATA_W-1:0] stage_data,
  output logic [DATA_W-1:0]       op1_data,
  output logic [DATA_W-1:0]       op2_data,
  output logic [SEL_W-1:0]        fwd_sel1,
  output logic [SEL_W-1:0]        fwd_sel2,
  output logic                    stall,
  output logic                    flush,
  output logic [CNT_W-1:0]        stall_cnt,
  output logic [CNT_W-1:0]        flush_cnt
);

  entry_t [DEPTH-1:0] entry_q, entry_d;
  logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]   flush_cnt_q, flush_cnt_d;

  logic               hit1, hit2, lu1, lu2;
  logic [SEL_W-1:0]   idx1, idx2;

  hazard_match #(
    .DEPTH(DEPTH), .REG_W(REG_W), .LOAD_READY(LOAD_READY), .SEL_W(SEL_W)
  ) u_match1 (
    .rs(dec_rs1), .used(dec_rs1_used), .entries(entry_q),
    .hit(hit1), .index(idx1), .load_use(lu1)
  );

  hazard_match #(
    .DEPTH(DEPTH), .REG_W(REG_W), .LOAD_READY(LOAD_READY), .SEL_W(SEL_W)
  ) u_match2 (
    .rs(dec_rs2), .used(dec_rs2_used), .entries(entry_q),
    .hit(hit2), .index(idx2), .load_use(lu2)
  );

  // The redirect wins: the decode instruction is wrong-path and is dropped anyway.
  assign flush = branch_taken;
  assign stall = dec_valid && (lu1 || lu2) && !branch_taken;

  always_comb begin
    fwd_sel1 = SEL_W'(FWD_RF);
    fwd_sel2 = SEL_W'(FWD_RF);
    op1_data = rf_rs1_data;
    op2_data = rf_rs2_data;
    for (int i = 0; i < DEPTH; i++) begin
      if (hit1 && !lu1 && (idx1 == SEL_W'(i))) begin
        fwd_sel1 = SEL_W'(i + 1);
        op1_data = stage_data[i*DATA_W +: DATA_W];
      end
      if (hit2 && !lu2 && (idx2 == SEL_W'(i))) begin
        fwd_sel2 = SEL_W'(i + 1);
        op2_data = stage_data[i*DATA_W +: DATA_W];
      end
    end
  end

  // Tags always advance; a stall or flush simply injects a bubble at entry 0.
  always_comb begin
    entry_d[0] = '0;
    if (dec_valid && !stall && !flush) begin
      entry_d[0].valid   = 1'b1;
      entry_d[0].rd      = MAX_REG_W'(dec_rd);
      entry_d[0].we      = dec_rd_we && (dec_rd != '0);
      entry_d[0].is_load = dec_is_load;
    end
    for (int i = 1; i < DEPTH; i++) begin
      entry_d[i] = entry_q[i-1];
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall && (stall_cnt_q != {CNT_W{1'b1}})) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (flush && (flush_cnt_q != {CNT_W{1'b1}})) flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its neighbour, which is what makes the chain shift.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      entry_q     <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      entry_q     <= entry_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_riscv_hazard_scoreboard.sv
// Directed bench for riscv_hazard_scoreboard: expectations are queued as each
// step is driven and drained against the DUT outputs once they settle.
module tb_riscv_hazard_scoreboard;

  localparam int DW = 32;

  logic              clk = 1'b0;
  logic              rst, s_rst;
  logic              dec_valid, dec_rs1_used, dec_rs2_used, dec_rd_we, dec_is_load;
  logic [4:0]        dec_rs1, dec_rs2, dec_rd;
  logic              branch_taken;
  logic              s_branch = 1'b0;
  logic [DW-1:0]     rf1, rf2;
  logic [3*DW-1:0]   stage_data;
  logic [5*DW-1:0]   s_stage_data;

  logic [DW-1:0]     op1, op2, s_op1, s_op2;
  logic [1:0]        sel1, sel2;
  logic [2:0]        s_sel1, s_sel2;
  logic              stall, flush, s_stall, s_flush;
  logic [15:0]       stall_cnt, flush_cnt;
  logic [1:0]        s_stall_cnt, s_flush_cnt;

  always #5 clk = ~clk;

  riscv_hazard_scoreboard dut (
    .clk(clk), .rst(rst), .dec_valid(dec_valid),
    .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
    .dec_rs1_used(dec_rs1_used), .dec_rs2_used(dec_rs2_used),
    .dec_rd(dec_rd), .dec_rd_we(dec_rd_we), .dec_is_load(dec_is_load),
    .branch_taken(branch_taken), .rf_rs1_data(rf1), .rf_rs2_data(rf2),
    .stage_data(stage_data), .op1_data(op1), .op2_data(op2),
    .fwd_sel1(sel1), .fwd_sel2(sel2), .stall(stall), .flush(flush),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  // Deep chain with late load data and a 2-bit counter: one load gives five
  // consecutive stalls, enough to drive the counter into saturation.
  riscv_hazard_scoreboard #(.DEPTH(5), .LOAD_READY(5), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(s_rst), .dec_valid(dec_valid),
    .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
    .dec_rs1_used(dec_rs1_used), .dec_rs2_used(dec_rs2_used),
    .dec_rd(dec_rd), .dec_rd_we(dec_rd_we), .dec_is_load(dec_is_load),
    .branch_taken(s_branch), .rf_rs1_data(rf1), .rf_rs2_data(rf2),
    .stage_data(s_stage_data), .op1_data(s_op1), .op2_data(s_op2),
    .fwd_sel1(s_sel1), .fwd_sel2(s_sel2), .stall(s_stall), .flush(s_flush),
    .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
  );

  typedef enum int {
    K_STALL, K_FLUSH, K_SEL1, K_SEL2, K_OP1, K_OP2, K_SCNT, K_FCNT,
    K_SAT_STALL, K_SAT_SCNT
  } kind_e;

  typedef struct {
    string       tag;
    kind_e       kind;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  function automatic logic [31:0] observe(input kind_e k);
    case (k)
      K_STALL:     return 32'(stall);
      K_FLUSH:     return 32'(flush);
      K_SEL1:      return 32'(sel1);
      K_SEL2:      return 32'(sel2);
      K_OP1:       return op1;
      K_OP2:       return op2;
      K_SCNT:      return 32'(stall_cnt);
      K_FCNT:      return 32'(flush_cnt);
      K_SAT_STALL: return 32'(s_stall);
      K_SAT_SCNT:  return 32'(s_stall_cnt);
      default:     return 32'hxxxx_xxxx;
    endcase
  endfunction

  task automatic push(input string tag, input kind_e k, input logic [31:0] v);
    exp_t e;
    e.tag  = tag;
    e.kind = k;
    e.val  = v;
    sb.push_back(e);
  endtask

  task automatic check();
    exp_t        e;
    logic [31:0] obs;
    while (sb.size() > 0) begin
      e   = sb.pop_front();
      obs = observe(e.kind);
      n_cmp++;
      assert (obs === e.val) else begin
        n_fail++;
        $error("FAIL %s: observed 0x%0h expected 0x%0h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic drive(input logic v, input logic [4:0] rs1, input logic u1,
                       input logic [4:0] rs2, input logic u2,
                       input logic [4:0] rd, input logic we, input logic ld);
    dec_valid    = v;
    dec_rs1      = rs1;
    dec_rs1_used = u1;
    dec_rs2      = rs2;
    dec_rs2_used = u2;
    dec_rd       = rd;
    dec_rd_we    = we;
    dec_is_load  = ld;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, summary not printed");
    $fatal(1);
  end

  localparam logic [31:0] RF1 = 32'hAAAA_0001;
  localparam logic [31:0] RF2 = 32'hBBBB_0002;

  initial begin
    rst          = 1'b0;
    s_rst        = 1'b0;
    branch_taken = 1'b0;
    rf1          = RF1;
    rf2          = RF2;
    stage_data   = {32'h33, 32'h22, 32'h11};
    s_stage_data = {32'h55, 32'h44, 32'h33, 32'h22, 32'h11};
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);

    // Reset state
    #3;
    push("rst_stall", K_STALL, 0);  push("rst_flush", K_FLUSH, 0);
    push("rst_sel1", K_SEL1, 0);    push("rst_sel2", K_SEL2, 0);
    push("rst_op1", K_OP1, RF1);    push("rst_op2", K_OP2, RF2);
    push("rst_scnt", K_SCNT, 0);    push("rst_fcnt", K_FCNT, 0);
    check();
    #9 rst = 1'b1;

    // Back-to-back dependency: add x5, then sub x6 reading x5
    tick(); drive(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 5'd5, 1'b1, 1'b0);
    #1; push("add_stall", K_STALL, 0); push("add_sel1", K_SEL1, 0); check();
    tick(); drive(1'b1, 5'd5, 1'b1, 5'd0, 1'b1, 5'd6, 1'b1, 1'b0);
    #1;
    push("b2b_sel1", K_SEL1, 1);  push("b2b_op1", K_OP1, 32'h11);
    push("b2b_stall", K_STALL, 0); push("b2b_sel2_x0", K_SEL2, 0);
    push("b2b_op2_x0", K_OP2, RF2);
    check();

    // Load-use: lw x7, then add reading x7
    tick(); drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd7, 1'b1, 1'b1);
    #1; push("lw_stall", K_STALL, 0); check();
    tick(); drive(1'b1, 5'd7, 1'b1, 5'd0, 1'b0, 5'd8, 1'b1, 1'b0);
    #1; push("lu_stall", K_STALL, 1); push("lu_scnt_before", K_SCNT, 0); check();
    tick();
    #1;
    push("lu_release", K_STALL, 0); push("lu_sel1", K_SEL1, 2);
    push("lu_op1", K_OP1, 32'h22);  push("lu_scnt", K_SCNT, 1);
    check();

    // Youngest writer wins: x9 in entries 0 and 2
    tick(); drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0);
    tick(); drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd4, 1'b1, 1'b0);
    tick(); drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd9, 1'b1, 1'b0);
    tick(); drive(1'b1, 5'd9, 1'b1, 5'd9, 1'b1, 5'd11, 1'b1, 1'b0);
    #1;
    push("prio_sel1", K_SEL1, 1);   push("prio_op1", K_OP1, 32'h11);
    push("prio_sel2", K_SEL2, 1);   push("prio_op2", K_OP2, 32'h11);
    push("prio_stall", K_STALL, 0);
    check();

    // x0 in flight never forwards; unused operand ignores a real match (x11)
    tick(); drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 1'b0);
    tick(); drive(1'b1, 5'd0, 1'b1, 5'd11, 1'b0, 5'd12, 1'b1, 1'b0);
    #1;
    push("x0_sel1", K_SEL1, 0);       push("x0_op1", K_OP1, RF1);
    push("unused_sel2", K_SEL2, 0);   push("unused_op2", K_OP2, RF2);
    check();

    // Flush beats stall: lw x13, then a dependent read while the branch resolves
    tick(); drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd13, 1'b1, 1'b1);
    tick(); drive(1'b1, 5'd13, 1'b1, 5'd0, 1'b0, 5'd14, 1'b1, 1'b0);
    branch_taken = 1'b1;
    #1;
    push("fl_flush", K_FLUSH, 1); push("fl_stall", K_STALL, 0);
    push("fl_fcnt_before", K_FCNT, 0);
    check();
    tick(); branch_taken = 1'b0;
    drive(1'b1, 5'd14, 1'b1, 5'd13, 1'b1, 5'd15, 1'b1, 1'b0);
    #1;
    push("fl_bubble_sel1", K_SEL1, 0); push("fl_bubble_op1", K_OP1, RF1);
    push("fl_lw_sel2", K_SEL2, 2);     push("fl_lw_op2", K_OP2, 32'h22);
    push("fl_after_stall", K_STALL, 0); push("fl_after_flush", K_FLUSH, 0);
    push("fl_fcnt", K_FCNT, 1);        push("fl_scnt", K_SCNT, 1);
    check();

    // Counter saturation on the 2-bit instance: five consecutive stalls
    #2 s_rst = 1'b1;
    tick(); drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd20, 1'b1, 1'b1);
    #1; push("sat_lw_stall", K_SAT_STALL, 0); check();
    tick(); drive(1'b1, 5'd20, 1'b1, 5'd0, 1'b0, 5'd21, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      #1;
      push($sformatf("sat_stall_%0d", i), K_SAT_STALL, 1);
      push($sformatf("sat_cnt_%0d", i), K_SAT_SCNT, (i > 3) ? 3 : i);
      check();
      tick();
    end
    #1;
    push("sat_release", K_SAT_STALL, 0); push("sat_final", K_SAT_SCNT, 3);
    check();

    // Reset mid-operation with x3 writers in flight
    tick(); drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0);
    tick(); drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 5'd3, 1'b1, 1'b0);
    tick(); drive(1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
    #1; push("pre_rst_sel1", K_SEL1, 1); check();
    #1 rst = 1'b0;
    #1;
    push("mid_rst_sel1", K_SEL1, 0); push("mid_rst_op1", K_OP1, RF1);
    push("mid_rst_stall", K_STALL, 0);
    push("mid_rst_scnt", K_SCNT, 0); push("mid_rst_fcnt", K_FCNT, 0);
    check();
    #1 rst = 1'b1;
    #1; push("post_rst_sel1", K_SEL1, 0); check();
    tick();
    #1;
    push("post_rst_edge_sel1", K_SEL1, 0); push("post_rst_edge_op1", K_OP1, RF1);
    check();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
